// File: rtl/return_stack_pkg.sv
// ---------------------------------------------------------------------------
// return_stack_pkg
//   Shared constants and types for the return-address stack.
//   ADDR_W       : PC / return-address width
//   RSTACK_DEPTH : number of stack entries (power of two)
//   RSTACK_PTRW  : log2(RSTACK_DEPTH)
//   rs_op_e      : operation decoded from {push, pop}
// ---------------------------------------------------------------------------
package return_stack_pkg;

  localparam int ADDR_W       = 10;
  localparam int RSTACK_DEPTH = 8;
  localparam int RSTACK_PTRW  = 3;

  // Encoding matches the raw {push, pop} pair so decode is a plain cast.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } rs_op_e;

  function automatic rs_op_e rs_decode(input logic push, input logic pop);
    return rs_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/return_stack_lifo_mem.sv
// ---------------------------------------------------------------------------
// lifo_mem
//   DEPTH x WIDTH storage for the return stack. Synchronous write,
//   combinational read, no reset (contents survive a stack reset).
//   clk : clock
//   we  : write enable
//   wa  : write address
//   wd  : write data
//   ra  : read address
//   rd  : read data (combinational from ra)
// ---------------------------------------------------------------------------
module lifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int PTRW  = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTRW-1:0]  wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [PTRW-1:0]  ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/return_stack.sv
// ---------------------------------------------------------------------------
// return_stack
//   Return-address LIFO for subroutine call/return. Holds the stack
//   pointer, occupancy count, sticky overflow/underflow flags and the
//   push/pop decode; storage lives in lifo_mem.
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-low reset
//   push  : push d (call)
//   pop   : discard top (return)
//   clr   : synchronous clear of ovf/udf
//   d     : return address to push
//   q     : top of stack, 0 when empty
//   empty : count == 0
//   full  : count == DEPTH
//   ovf   : sticky, push while full
//   udf   : sticky, pop while empty
// ---------------------------------------------------------------------------
module return_stack
  import return_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = RSTACK_DEPTH,
  parameter int PTRW  = RSTACK_PTRW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             udf
);

  localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);

  logic [PTRW-1:0]  sp_q, sp_d;
  logic [PTRW:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             mem_we;
  logic [PTRW-1:0]  mem_wa;
  logic [PTRW-1:0]  top_ptr;
  logic [WIDTH-1:0] mem_rd;
  rs_op_e           op;

  assign op      = rs_decode(push, pop);
  assign top_ptr = sp_q - PTR_ONE;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign q       = empty ? '0 : mem_rd;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    // Clear first; any set below overrides it in the same cycle.
    ovf_d  = ovf_q & ~clr;
    udf_d  = udf_q & ~clr;
    mem_we = 1'b0;
    mem_wa = sp_q;

    unique case (op)
      OP_HOLD: ;
      OP_PUSH: begin
        mem_we = 1'b1;
        sp_d   = sp_q + PTR_ONE;
        // When full, sp already points at the oldest entry, so the
        // write overwrites it and the count saturates.
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OP_POP: begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          sp_d  = top_ptr;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      OP_REPL: begin
        mem_we = 1'b1;
        if (empty) begin
          // Nothing to replace: acts as a plain push, no flags.
          sp_d  = sp_q + PTR_ONE;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          mem_wa = top_ptr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_mem (
    .clk (clk),
    .we  (mem_we),
    .wa  (mem_wa),
    .wd  (d),
    .ra  (top_ptr),
    .rd  (mem_rd)
  );

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware return-address stack (LIFO) for subroutine call/return.
- Sits between the PC incrementer (sum, 10-bit PC+1) and the PC-select mux.
- On a call, the control unit pushes PC+1. On a return, it pops, and the top-of-stack output drives a mux input as the next PC.
- Single clock domain. Flags go to the control unit and the debug status register.

Parameters:
- WIDTH, 10, address width in bits; matches the PC/sum width.
- DEPTH, 8, number of entries; must be a power of two.
- PTRW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  store d as the new top of stack (call).
- pop  input  1  discard the current top of stack (return).
- clr  input  1  synchronous clear of the ovf/udf sticky flags.
- d  input  WIDTH  return address to push (PC+1 from sum).
- q  output  WIDTH  current top-of-stack entry; combinational from storage.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- ovf  output  1  sticky: a push was issued while full.
- udf  output  1  sticky: a pop was issued while empty.

Behaviour:
- Reset (reset low, asynchronous, no clock needed):
  - sp=0, count=0, ovf=0, udf=0.
  - Outputs: q=0, empty=1, full=0.
  - Storage contents are not cleared.
- State:
  - sp (PTRW bits) points to the next free slot and wraps modulo DEPTH.
  - count is PTRW+1 bits, range 0..DEPTH.
- Outputs:
  - q = mem[sp-1 mod DEPTH] when count>0; q = 0 when empty.
  - q, empty and full reflect the post-edge state in the cycle after an operation. Zero added latency on the read side.
- Operation per rising edge, on {push,pop}:
  - 00: hold.
  - 10, not full: mem[sp]<=d; sp<=sp+1; count<=count+1.
  - 10, full: wrap-around overwrite of the oldest entry. mem[sp]<=d; sp<=sp+1; count stays DEPTH; ovf<=1.
  - 01, not empty: sp<=sp-1; count<=count-1. The popped value is the q presented during that cycle.
  - 01, empty: no state change; udf<=1; q stays 0.
  - 11, not empty: replace top. mem[sp-1]<=d; sp and count unchanged; no flag change, including when full.
  - 11, empty: behaves as 10 (push); udf is not set.
- Flags:
  - ovf and udf are cleared by reset, or by clr at a clock edge.
  - If clr coincides with a set condition in the same cycle, set wins.
- Arithmetic:
  - Pointer arithmetic is modulo 2^PTRW and has no carry out.
  - d is stored unmodified; no width extension.
- Reset during an operation: asynchronous reset overrides any push/pop in progress. The first edge after reset releases performs only the requested operation on an empty stack.
- push/pop are sampled only at the clock edge. Inputs are expected stable around the edge; no internal synchronisation.

Decomposition:
- Shared constants go in the common processor include file: ADDR_W=10, RSTACK_DEPTH=8, RSTACK_PTRW=3. The processor top instantiates the block with these values.
- One sub-module: lifo_mem.
  - Ports: clk, we, wa[PTRW], wd[WIDTH], ra[PTRW], rd[WIDTH].
  - DEPTH x WIDTH array, synchronous write, combinational read, no reset.
- The return_stack top holds sp, count, the flags and the operation decode.

Test Plan:
1. Reset low, then release -> q=0, empty=1, full=0, ovf=0, udf=0. Push 10'h012, 10'h034, 10'h056 -> q=10'h056, count 3. Pop -> q=10'h034. Pop -> q=10'h012. Pop -> empty=1, q=0.
2. Push 10'h100..10'h107 (8 pushes) -> full=1, q=10'h107. Push 10'h3FF -> ovf=1, full=1, q=10'h3FF. Pop 7 times -> q=10'h101 (10'h100 lost). Pop again -> empty=1.
3. Empty stack, pop -> udf=1, q=0, empty=1. Assert clr one cycle -> udf=0. Pop together with clr on an empty stack -> udf=1 (set wins).
4. Stack holding 10'h020,10'h040, assert push+pop with d=10'h2AA -> q=10'h2AA, count stays 2. Pop -> q=10'h020. Push+pop on an empty stack with d=10'h001 -> q=10'h001, empty=0, udf=0.
5. Push 10'h0F0, 10'h0F1, then drive reset low mid-cycle while push is high with d=10'h0F2 -> immediately q=0, empty=1. Release, next edge pushes 10'h0F2 -> q=10'h0F2, count 1.
6. Full stack, push+pop with d=10'h155 -> q=10'h155, full=1, ovf stays 0.
